interval_timer: RTL and testbench

//  Countdown timer directly downstream of TimeParameter: loads the 4-bit interval

---
 rtl/interval_timer_pkg.sv | 15 +
 rtl/interval_timer_tick_divider.sv | 39 +++
 rtl/interval_timer.sv | 122 ++++++++++++
 tb/tb_interval_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: countdown state encoding and
// default sizing used by the timer and its neighbours.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COUNT  = 2'd2,
    ST_EXPIRE = 2'd3
  } state_e;

  localparam int VALUE_W_DEF  = 4;
  localparam int SIM_TICK_DIV = 4;

endpackage

// File: rtl/interval_timer_tick_divider.sv
// Clock-to-seconds prescaler: emits a registered one-cycle tick every TICK_DIV
// enabled cycles; dropping en clears the count so the next run starts aligned.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] div_cnt_r;
  logic             tick_r;

  // Tick is registered one cycle ahead so it is high exactly while div_cnt_r holds its last value.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else if (en) begin
      if (div_cnt_r == CNT_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + 1'b1;
      end
      tick_r <= (div_cnt_r == CNT_PRE);
    end else begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/interval_timer.sv
// Countdown timer for the light controller: loads an interval in seconds,
// counts it down on the prescaler tick and pulses expired when it runs out.
module interval_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int VALUE_W  = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Start_timer,
  input  logic               Prog_Sync,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining,
  output logic               sec_tick
);

  import interval_timer_pkg::*;

  localparam logic [VALUE_W-1:0] REM_ZERO = '0;
  localparam logic [VALUE_W-1:0] REM_ONE  = VALUE_W'(1);

  state_e             state_r;
  logic [VALUE_W-1:0] remaining_r;
  logic               expired_r;
  logic               busy_r;
  logic               tick_s;
  logic               tick_en_s;

  // Prescaler runs only while counting undisturbed, so any exit from COUNT zeroes it.
  assign tick_en_s = (state_r == ST_COUNT) && !Prog_Sync && !Start_timer;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .Reset(Reset),
    .en   (tick_en_s),
    .tick (tick_s)
  );

  // Countdown FSM; busy and expired are registered against the state being entered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      expired_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else if (Prog_Sync) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      expired_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      expired_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Start_timer) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          remaining_r <= value;
          if (Start_timer) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else if (value == REM_ZERO) begin
            state_r   <= ST_EXPIRE;
            busy_r    <= 1'b0;
            expired_r <= 1'b1;
          end else begin
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (Start_timer) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else if (tick_s && (remaining_r != REM_ZERO)) begin
            remaining_r <= remaining_r - REM_ONE;
            if (remaining_r == REM_ONE) begin
              state_r   <= ST_EXPIRE;
              busy_r    <= 1'b0;
              expired_r <= 1'b1;
            end else begin
              state_r <= ST_COUNT;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
          end
        end
        ST_EXPIRE: begin
          if (Start_timer) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          remaining_r <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign expired   = expired_r;
  assign busy      = busy_r;
  assign remaining = remaining_r;
  assign sec_tick  = tick_s;

endmodule

// File: tb/tb_interval_timer.sv
// Randomized scoreboard bench for interval_timer: a per-cycle expectation table
// and an expiry queue are built from the timing rules and checked by a monitor.
module tb_interval_timer;

  localparam int TD   = 4;
  localparam int VW   = 4;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start_timer = 1'b0;
  logic          Prog_Sync = 1'b0;
  logic [VW-1:0] value = '0;
  logic          expired;
  logic          busy;
  logic [VW-1:0] remaining;
  logic          sec_tick;

  interval_timer #(.TICK_DIV(TD), .VALUE_W(VW)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Start_timer(Start_timer),
    .Prog_Sync  (Prog_Sync),
    .value      (value),
    .expired    (expired),
    .busy       (busy),
    .remaining  (remaining),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected per-cycle view and queue of cycles at which expired must pulse
  bit            exp_busy [MAXC];
  bit            exp_tick [MAXC];
  logic [VW-1:0] exp_rem  [MAXC];
  bit            rem_chk  [MAXC];
  int            exp_q[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  bit  pend = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  function automatic void set_idle(input int from, input int to);
    for (int c = from; c <= to && c < MAXC; c++) begin
      exp_busy[c] = 1'b0;
      exp_tick[c] = 1'b0;
      exp_rem[c]  = '0;
      rem_chk[c]  = 1'b1;
    end
  endfunction

  // timer started in cycle s, value v seen in the load cycle s+1
  function automatic void fill(input int s, input int v);
    int e;
    e = s + 2 + TD * v;
    if (s + 1 < MAXC) begin
      exp_busy[s+1] = 1'b1;
      exp_tick[s+1] = 1'b0;
      rem_chk[s+1]  = 1'b0;
    end
    for (int c = s + 2; c < e && c < MAXC; c++) begin
      exp_busy[c] = 1'b1;
      exp_rem[c]  = VW'(v - (c - s - 2) / TD);
      rem_chk[c]  = 1'b1;
      exp_tick[c] = (((c - s - 2) % TD) == TD - 1);
    end
    set_idle(e, e);
    exp_q.push_back(e);
  endfunction

  // an abort or restart in cycle k discards any countdown that would end after k
  function automatic void cancel(input int k);
    int e;
    while (exp_q.size() > 0 && exp_q[$] > k) begin
      e = exp_q.pop_back();
      set_idle(k + 1, e);
    end
  endfunction

  task automatic drive(input bit st, input bit ps, input logic [VW-1:0] v);
    int c;
    @(posedge clk);
    #1;
    Start_timer = st;
    Prog_Sync   = ps;
    value       = v;
    c = cyc;
    if (pend) fill(c - 1, int'(v));
    if (ps || st) cancel(c);
    pend = st && !ps;
  endtask

  task automatic start_t(input int v);
    drive(1'b1, 1'b0, VW'($urandom));
    drive(1'b0, 1'b0, VW'(v));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, VW'($urandom));
  endtask

  // monitor: compares every cycle against the table and the expiry queue
  always @(negedge clk) begin
    if (mon_en) begin
      int c;
      bit ee;
      c  = cyc;
      ee = (exp_q.size() > 0) && (exp_q[0] == c);
      check("expired", int'(expired), int'(ee));
      if (ee) void'(exp_q.pop_front());
      check("busy", int'(busy), int'(exp_busy[c]));
      check("sec_tick", int'(sec_tick), int'(exp_tick[c]));
      if (rem_chk[c]) check("remaining", int'(remaining), int'(exp_rem[c]));
    end
  end

  initial begin
    set_idle(0, MAXC - 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_sec_tick", int'(sec_tick), 0);
    check("rst_remaining", int'(remaining), 0);
    Reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // plain countdown, zero interval, longest interval with value wobbling mid-count
    start_t(3);  idle(16);
    start_t(0);  idle(4);
    start_t(15); idle(3); drive(1'b0, 1'b0, 4'd2); idle(64);
    // restart mid-count
    start_t(3);  idle(5); start_t(1); idle(16);
    // abort while restart requested, then a fresh start
    start_t(3);  idle(4);
    drive(1'b0, 1'b1, VW'($urandom));
    drive(1'b1, 1'b1, VW'($urandom));
    drive(1'b0, 1'b1, VW'($urandom));
    idle(1);
    start_t(3);  idle(16);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit st;
      bit ps;
      logic [VW-1:0] v;
      st = ($urandom_range(0, 11) == 0);
      ps = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) == 0) ? VW'($urandom_range(0, 1)) : VW'($urandom);
      drive(st, ps, v);
    end
    idle(70);
    check("queue_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a countdown
    start_t(3); idle(4);
    @(posedge clk);
    #3;
    set_idle(cyc, MAXC - 1);
    exp_q.delete();
    pend  = 1'b0;
    Reset = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_remaining", int'(remaining), 0);
    check("async_sec_tick", int'(sec_tick), 0);
    check("async_expired", int'(expired), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    idle(20);
    start_t(2); idle(12);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
